// File: rtl/alu_mdu_pkg.sv
// Shared op-code and FSM state definitions for the execute-stage ALU and its
// iterative multiply/divide datapath.
package alu_mdu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    OP_AND    = 5'd0,
    OP_OR     = 5'd1,
    OP_XOR    = 5'd2,
    OP_ANDN   = 5'd3,
    OP_ORN    = 5'd4,
    OP_ADD    = 5'd5,
    OP_SUB    = 5'd6,
    OP_SLT    = 5'd7,
    OP_SLTU   = 5'd8,
    OP_SLL    = 5'd9,
    OP_SRL    = 5'd10,
    OP_SRA    = 5'd11,
    OP_MUL    = 5'd12,
    OP_MULH   = 5'd13,
    OP_MULHSU = 5'd14,
    OP_MULHU  = 5'd15,
    OP_DIV    = 5'd16,
    OP_DIVU   = 5'd17,
    OP_REM    = 5'd18,
    OP_REMU   = 5'd19
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative RV32M-style multiply/divide datapath: one shift-add or restoring
// divide step per cycle on operand magnitudes, with sign fixup on the last step.
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            abort_i,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic              busy_q;
  logic [SHW-1:0]    cnt_q;
  logic              div_q;
  logic              hi_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;

  logic              st_div, st_sa, st_sb, st_hi, st_neg;
  logic [XLEN-1:0]   st_ma, st_mb;

  always_comb begin
    st_div = is_div_op(op_i);
    st_sa  = a_i[XLEN-1] && (op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    st_sb  = b_i[XLEN-1] && (op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    st_ma  = st_sa ? -a_i : a_i;
    st_mb  = st_sb ? -b_i : b_i;
    st_hi  = op_i inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
    st_neg = (op_i inside {OP_REM, OP_REMU}) ? st_sa : (st_sa ^ st_sb);
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_part;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] acc_n;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   div_raw;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_part - {1'b0, opnd_q};
    div_ge   = !div_diff[XLEN];
    div_rem  = div_ge ? div_diff[XLEN-1:0] : div_part[XLEN-1:0];
    acc_n    = div_q ? {div_rem, acc_q[XLEN-2:0], div_ge}
                     : {mul_sum, acc_q[XLEN-1:1]};
    prod_s   = neg_q ? -acc_n : acc_n;
    div_raw  = hi_q ? acc_n[2*XLEN-1:XLEN] : acc_n[XLEN-1:0];
    if (div_q) begin
      result_o = neg_q ? -div_raw : div_raw;
    end else begin
      result_o = hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
    done_o = busy_q && (cnt_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= SHW'(XLEN - 1);
      div_q  <= st_div;
      hi_q   <= st_hi;
      neg_q  <= st_neg;
      opnd_q <= st_div ? st_mb : st_ma;
      acc_q  <= {{XLEN{1'b0}}, (st_div ? st_ma : st_mb)};
    end else if (busy_q) begin
      acc_q <= acc_n;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with valid/ready handshakes on both sides; single-cycle ops
// and divide fast paths resolve here, MUL*/DIV*/REM* iterate in mdu_iter.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_ctrl,
  input  logic [XLEN-1:0] i_dataa,
  input  logic [XLEN-1:0] i_datab,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_of
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            of_q, of_d;

  logic [XLEN-1:0] a, b, sum, diff;
  logic [SHW-1:0]  shamt;
  logic            div_zero, div_ovf, fast, multi, accept;
  logic [XLEN-1:0] alu_res;
  logic            alu_of;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_result;

  always_comb begin
    a        = i_dataa;
    b        = i_datab;
    shamt    = b[SHW-1:0];
    sum      = a + b;
    diff     = a - b;
    div_zero = (b == '0);
    div_ovf  = (i_ctrl inside {OP_DIV, OP_REM}) && (a == MIN_INT) && (b == '1);
    fast     = is_div_op(i_ctrl) && (div_zero || div_ovf);
    multi    = is_mdu_op(i_ctrl) && !fast;

    alu_res = '0;
    alu_of  = 1'b0;
    case (i_ctrl)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ANDN: alu_res = a & ~b;
      OP_ORN:  alu_res = a | ~b;
      OP_ADD: begin
        alu_res = sum;
        alu_of  = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_of  = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      // Only reached on the divide fast paths; iterative results come from mdu_iter
      OP_DIV, OP_DIVU: alu_res = div_zero ? '1 : a;
      OP_REM, OP_REMU: alu_res = div_zero ? a : '0;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    o_ready = !i_flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready));
    accept  = i_valid && o_ready;
    state_d = state_q;
    res_d   = res_q;
    of_d    = of_q;
    if (i_flush) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      if (multi) begin
        state_d = ST_BUSY;
      end else begin
        state_d = ST_DONE;
        res_d   = alu_res;
        of_d    = alu_of;
      end
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (mdu_done) begin
            state_d = ST_DONE;
            res_d   = mdu_result;
            of_d    = 1'b0;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      of_q    <= of_d;
    end
  end

  assign o_valid  = (state_q == ST_DONE);
  assign o_result = res_q;
  assign o_of     = of_q;

  mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .abort_i (i_flush),
    .start_i (accept && multi),
    .op_i    (i_ctrl),
    .a_i     (i_dataa),
    .b_i     (i_datab),
    .done_o  (mdu_done),
    .result_o(mdu_result)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed corner cases plus random ops checked
// against a plain-arithmetic reference model.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid, ready, ovalid, iready, of;
  logic [4:0]  ctrl;
  logic [31:0] dataa, datab, result;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_valid (valid),
    .o_ready (ready),
    .i_ctrl  (ctrl),
    .i_dataa (dataa),
    .i_datab (datab),
    .o_valid (ovalid),
    .i_ready (iready),
    .o_result(result),
    .o_of    (of)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o, output int lat);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0; o = 1'b0; lat = 1; p = 0; pu = 0;
    case (c)
      5'd0: r = a & b;
      5'd1: r = a | b;
      5'd2: r = a ^ b;
      5'd3: r = a & ~b;
      5'd4: r = a | ~b;
      5'd5: begin p = sa + sb; r = p[31:0]; o = (p > 64'sd2147483647) || (p < -64'sd2147483648); end
      5'd6: begin p = sa - sb; r = p[31:0]; o = (p > 64'sd2147483647) || (p < -64'sd2147483648); end
      5'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      5'd8: r = (ua < ub) ? 32'd1 : 32'd0;
      5'd9: r = a << b[4:0];
      5'd10: r = a >> b[4:0];
      5'd11: begin p = sa >>> b[4:0]; r = p[31:0]; end
      5'd12: begin p = sa * sb; r = p[31:0]; lat = 33; end
      5'd13: begin p = sa * sb; r = p[63:32]; lat = 33; end
      5'd14: begin p = sa * longint'(ub); r = p[63:32]; lat = 33; end
      5'd15: begin pu = ua * ub; r = pu[63:32]; lat = 33; end
      5'd16: if (b == 0) r = '1; else if (ovf) r = a;
             else begin p = sa / sb; r = p[31:0]; lat = 33; end
      5'd17: if (b == 0) r = '1; else begin pu = ua / ub; r = pu[31:0]; lat = 33; end
      5'd18: if (b == 0) r = a; else if (ovf) r = '0;
             else begin p = sa % sb; r = p[31:0]; lat = 33; end
      5'd19: if (b == 0) r = a; else begin pu = ua % ub; r = pu[31:0]; lat = 33; end
      default: r = '0;
    endcase
  endfunction

  // Issue one op from IDLE, scramble operands after accept, measure cycles to o_valid.
  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic o, output int lat);
    int w;
    @(negedge clk);
    ctrl = c; dataa = a; datab = b; valid = 1'b1; iready = 1'b1;
    #1;
    w = 0;
    while (!ready && w < 50) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk);
    #1;
    valid = 1'b0; dataa = $urandom; datab = $urandom;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!ovalid && lat < 60);
    r = result; o = of;
  endtask

  task automatic directed(input string tag, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic eo, input int el);
    logic [31:0] r; logic o; int lat;
    run_op(c, a, b, r, o, lat);
    check({tag, "_res"}, r, er);
    check({tag, "_of"}, o, eo);
    check({tag, "_lat"}, lat, el);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, er, r0;
    logic        o, eo;
    int          lat, elat, seen, w;
    logic [4:0]  c;
    logic [31:0] a, b;

    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; iready = 1'b1;
    ctrl = '0; dataa = '0; datab = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", ovalid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_of", of, 1'b0);
    check("rst_ready", ready, 1'b1);
    rst_n = 1'b1;

    directed("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1);
    directed("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    directed("sra", OP_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1);
    directed("sltu", OP_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1);
    directed("slt", OP_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
    directed("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
    directed("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    directed("mul", OP_MUL, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 1'b0, 33);
    directed("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    directed("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    directed("divu0", OP_DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1'b0, 1);
    directed("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    directed("code25", 5'd25, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 1'b0, 1);

    // Backpressure in DONE, then simultaneous drain and issue.
    @(negedge clk);
    ctrl = OP_ADD; dataa = 32'd1; datab = 32'd2; valid = 1'b1; iready = 1'b0;
    @(posedge clk); #1 valid = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!ovalid && w < 10);
    ctrl = OP_SUB; dataa = 32'd10; datab = 32'd3; valid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", ovalid, 1'b1);
      check("bp_result", result, 32'd3);
      check("bp_ready", ready, 1'b0);
      @(negedge clk); #1;
    end
    iready = 1'b1;
    #1 check("bp_ready_rel", ready, 1'b1);
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", ovalid, 1'b1);
    check("b2b_result", result, 32'd7);

    // Flush during iteration 10 of a divide.
    @(negedge clk);
    ctrl = OP_DIV; dataa = 32'd100; datab = 32'd7; valid = 1'b1; iready = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; valid = 1'b1; ctrl = OP_ADD; dataa = 32'd1; datab = 32'd1;
    #1 check("flush_ready", ready, 1'b0);
    @(posedge clk); #1 flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("post_flush_ready", ready, 1'b1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (ovalid) seen++;
      @(negedge clk);
    end
    check("flush_no_valid", seen, 0);
    directed("post_flush_div", OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 33);

    // Reset mid-divide, with o_result/o_of left non-zero beforehand.
    directed("add_ovf2", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1);
    @(negedge clk);
    ctrl = OP_DIV; dataa = 32'hFFFF_FFF9; datab = 32'd2; valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", ovalid, 1'b0);
    check("midrst_result", result, 32'h0);
    check("midrst_of", of, 1'b0);
    rst_n = 1'b1;
    directed("post_rst_remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33);

    for (int i = 0; i < 80; i++) begin
      c = ($urandom % 5 == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
      a = rnd_operand();
      b = rnd_operand();
      model(c, a, b, er, eo, elat);
      run_op(c, a, b, r, o, lat);
      check("rnd_res", r, er);
      check("rnd_of", o, eo);
      check("rnd_lat", lat, elat);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
